// File: rtl/process_images_mul_pkg.sv
//------------------------------------------------------------------------------
// Module      : process_images_mul_pkg
// Description : Shared constants and types for the process_images multiplier
//               arbiter (requester count, operand width, output FSM states).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package process_images_mul_pkg;

  localparam int N_REQ = 4;   // number of requesters sharing the multiplier
  localparam int MUL_W = 20;  // operand / result width
  localparam int ID_W  = 2;   // requester index width, clog2(N_REQ)

  typedef logic signed [MUL_W-1:0] mul_operand_t;

  // Output register occupancy
  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_t;

endpackage

`default_nettype wire

// File: rtl/process_images_mul_core.sv
//------------------------------------------------------------------------------
// Module      : process_images_mul_core
// Description : Signed W x W -> W truncating multiplier. The result is the low
//               W bits of the full two's-complement product (wraps, never
//               saturates).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module process_images_mul_core #(
  parameter int W = 20
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] p
);

  // The low W bits of a product only depend on the low W bits of the
  // operands, so evaluating in a W-bit context yields the truncated result
  assign p = a * b;

endmodule

`default_nettype wire

// File: rtl/process_images_rr_arbiter.sv
//------------------------------------------------------------------------------
// Module      : process_images_rr_arbiter
// Description : Purely combinational round-robin search. Scans req starting at
//               ptr, wrapping N-1 -> 0; the first set bit wins. The grant is
//               gated by enable, the encoded index is not.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module process_images_rr_arbiter
  import process_images_mul_pkg::*;
#(
  parameter int N   = N_REQ,
  parameter int IDW = ID_W
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  input  logic           enable,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] idx,
  output logic           any
);

  // Rotating priority search from ptr; first requester found wins
  always_comb begin
    int             pos;
    logic [IDW-1:0] pos_idx;
    grant   = '0;
    idx     = '0;
    any     = 1'b0;
    pos     = 0;
    pos_idx = '0;
    for (int k = 0; k < N; k++) begin
      pos = int'(ptr) + k;
      if (pos >= N) begin
        pos = pos - N;
      end
      pos_idx = IDW'(pos);
      if (!any && req[pos_idx]) begin
        any = 1'b1;
        idx = pos_idx;
      end
    end
    if (any && enable) begin
      grant[idx] = 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/process_images_mul_arbiter.sv
//------------------------------------------------------------------------------
// Module      : process_images_mul_arbiter
// Description : Shares one signed truncating multiplier among N requesters.
//               Round-robin grant, valid/ready per requester, and a single
//               registered response tagged with the requester index.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module process_images_mul_arbiter
  import process_images_mul_pkg::*;
#(
  parameter int N   = N_REQ,
  parameter int W   = MUL_W,
  parameter int IDW = ID_W
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic             en,
  input  logic [N-1:0]     req_valid,
  output logic [N-1:0]     req_ready,
  input  logic [N*W-1:0]   req_a,
  input  logic [N*W-1:0]   req_b,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [W-1:0]     resp_data,
  output logic [IDW-1:0]   resp_id,
  output logic [31:0]      op_count
);

  out_state_t          state;
  out_state_t          state_next;
  logic [IDW-1:0]      rr_ptr;
  logic                accept_en;
  logic                accept;
  logic                win_any;
  logic [IDW-1:0]      win_idx;
  logic [N-1:0]        grant;
  logic signed [W-1:0] op_a;
  logic signed [W-1:0] op_b;
  logic signed [W-1:0] product;

  // A new grant is possible when the output slot is free or being drained.
  // Gating with ap_rst_n keeps req_ready low for the whole reset.
  assign accept_en = ap_rst_n & en & ((state == EMPTY) | resp_ready);

  process_images_rr_arbiter #(
    .N   (N),
    .IDW (IDW)
  ) u_arb (
    .req    (req_valid),
    .ptr    (rr_ptr),
    .enable (accept_en),
    .grant  (grant),
    .idx    (win_idx),
    .any    (win_any)
  );

  assign req_ready = grant;
  assign accept    = win_any & accept_en;

  // Operands of the winning requester feed the single multiplier
  assign op_a = req_a[win_idx*W +: W];
  assign op_b = req_b[win_idx*W +: W];

  process_images_mul_core #(
    .W (W)
  ) u_mul (
    .a (op_a),
    .b (op_b),
    .p (product)
  );

  assign resp_valid = (state == FULL);

  // Output FSM state register
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // Output FSM next state: a load always wins over a drain
  always_comb begin
    state_next = state;
    case (state)
      EMPTY: begin
        if (accept) begin
          state_next = FULL;
        end
      end
      FULL: begin
        if (accept) begin
          state_next = FULL;
        end else if (resp_ready) begin
          state_next = EMPTY;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  // Response register, accept counter and round-robin pointer; all hold
  // when nothing is accepted
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      resp_data <= '0;
      resp_id   <= '0;
      op_count  <= '0;
      rr_ptr    <= '0;
    end else if (accept) begin
      resp_data <= product;
      resp_id   <= win_idx;
      op_count  <= op_count + 32'd1;
      rr_ptr    <= (win_idx == IDW'(N - 1)) ? '0 : win_idx + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_process_images_mul_arbiter.sv
//------------------------------------------------------------------------------
// Module      : tb_process_images_mul_arbiter
// Description : Self-checking bench with a reference arbitration model and a
//               response scoreboard for process_images_mul_arbiter.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_process_images_mul_arbiter;

  localparam int N = 4;
  localparam int W = 20;

  typedef struct {
    logic [1:0]   id;
    logic [W-1:0] data;
  } resp_t;

  logic           ap_clk;
  logic           ap_rst_n;
  logic           en;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic           resp_valid;
  logic           resp_ready;
  logic [W-1:0]   resp_data;
  logic [1:0]     resp_id;
  logic [31:0]    op_count;

  logic [W-1:0] a_arr [N];
  logic [W-1:0] b_arr [N];

  int total;
  int bad;

  // Reference model state
  logic        m_full;
  int          m_ptr;
  logic [31:0] m_count;
  resp_t       sb [$];

  process_images_mul_arbiter #(
    .N   (N),
    .W   (W),
    .IDW (2)
  ) dut (
    .ap_clk     (ap_clk),
    .ap_rst_n   (ap_rst_n),
    .en         (en),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_id    (resp_id),
    .op_count   (op_count)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  // Pack per-requester operands into the flat ports
  always_comb begin
    req_a = '0;
    req_b = '0;
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = a_arr[i];
      req_b[i*W +: W] = b_arr[i];
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: full 2W-bit signed product, keep the low W bits
  function automatic logic [W-1:0] mulw(input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [2*W-1:0] p;
    p = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
    return p[W-1:0];
  endfunction

  // Model and scoreboard, evaluated mid-cycle with stable inputs
  always @(negedge ap_clk) begin
    logic         exp_en;
    int           g;
    int           p;
    logic [N-1:0] exp_ready;
    resp_t        item;
    if (!ap_rst_n) begin
      m_full  = 1'b0;
      m_ptr   = 0;
      m_count = '0;
      sb.delete();
      chk("rst_ready", req_ready, 0);
      chk("rst_valid", resp_valid, 0);
    end else begin
      exp_en = en && (!m_full || resp_ready);
      g = -1;
      for (int k = 0; k < N; k++) begin
        p = (m_ptr + k) % N;
        if (g < 0 && req_valid[p]) g = p;
      end
      exp_ready = (exp_en && g >= 0) ? N'(1 << g) : '0;
      chk("req_ready", req_ready, exp_ready);
      chk("resp_valid", resp_valid, m_full);
      chk("op_count", op_count, m_count);
      if (m_full) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 1, 0);
        end else begin
          chk("resp_data", resp_data, sb[0].data);
          chk("resp_id", resp_id, sb[0].id);
        end
      end
      if (m_full && resp_ready && sb.size() > 0) void'(sb.pop_front());
      if (exp_en && g >= 0) begin
        item.id   = 2'(g);
        item.data = mulw(a_arr[g], b_arr[g]);
        sb.push_back(item);
        m_ptr   = (g + 1) % N;
        m_full  = 1'b1;
        m_count = m_count + 1;
      end else if (resp_ready) begin
        m_full = 1'b0;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge ap_clk);
      #1;
    end
  endtask

  initial begin
    logic [N-1:0] acc;
    logic [W-1:0] stall_exp;
    total      = 0;
    bad        = 0;
    ap_rst_n   = 1'b0;
    en         = 1'b1;
    resp_ready = 1'b1;
    req_valid  = '1;
    for (int i = 0; i < N; i++) begin
      a_arr[i] = W'(100 * (i + 1) + 7);
      b_arr[i] = W'(-(i + 3));
    end

    // Reset with everybody requesting
    step(3);
    chk("reset_ready_direct", req_ready, 0);
    ap_rst_n = 1'b1;
    step(1);
    chk("first_valid", resp_valid, 1);
    chk("first_id", resp_id, 0);
    step(7);
    chk("rr_count8", op_count, 8);
    chk("rr_last_id", resp_id, 3);

    // Single requester 1: -3 * 5
    req_valid = '0;
    step(2);
    a_arr[1]  = 20'hFFFFD;
    b_arr[1]  = 20'd5;
    req_valid = 4'b0010;
    step(1);
    req_valid = '0;
    chk("neg_data", resp_data, 20'hFFFF1);
    chk("neg_id", resp_id, 1);
    chk("neg_count", op_count, 9);

    // Overflow wrap cases
    a_arr[2]  = 20'h40000;
    b_arr[2]  = 20'd4;
    req_valid = 4'b0100;
    step(1);
    chk("ovf1_data", resp_data, 20'h00000);
    a_arr[3]  = 20'h7FFFF;
    b_arr[3]  = 20'h7FFFF;
    req_valid = 4'b1000;
    step(1);
    req_valid = '0;
    chk("ovf2_data", resp_data, 20'h00001);
    chk("ovf2_id", resp_id, 3);

    // Back-pressure while FULL
    req_valid = '1;
    stall_exp = mulw(a_arr[0], b_arr[0]);
    step(1);
    resp_ready = 1'b0;
    step(5);
    chk("stall_data", resp_data, stall_exp);
    chk("stall_id", resp_id, 0);
    chk("stall_ready", req_ready, 0);
    resp_ready = 1'b1;
    step(1);
    chk("release_valid", resp_valid, 1);
    chk("release_id", resp_id, 1);
    chk("release_count", op_count, 13);

    // Enable low: drain, then nothing granted
    en = 1'b0;
    step(4);
    chk("en0_count", op_count, 13);
    chk("en0_ready", req_ready, 0);
    chk("en0_valid", resp_valid, 0);
    en = 1'b1;

    // Random traffic; operands only change once a request is taken or idle
    for (int c = 0; c < 200; c++) begin
      @(negedge ap_clk);
      acc = req_valid & req_ready;
      @(posedge ap_clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] || acc[i]) begin
          req_valid[i] = ($urandom_range(0, 3) != 0);
          a_arr[i]     = W'($urandom);
          b_arr[i]     = W'($urandom);
        end
      end
      resp_ready = ($urandom_range(0, 3) != 0);
      en         = ($urandom_range(0, 7) != 0);
    end

    // Reset while FULL drops the in-flight result at once
    en         = 1'b1;
    resp_ready = 1'b1;
    req_valid  = '1;
    step(1);
    ap_rst_n = 1'b0;
    #1;
    chk("midrst_valid", resp_valid, 0);
    chk("midrst_count", op_count, 0);
    step(2);
    ap_rst_n = 1'b1;
    step(1);
    chk("midrst_ptr_id", resp_id, 0);
    req_valid = '0;
    step(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
